// File: rtl/proc_trace_commit_buffer.sv
// Realigns F-stage {addr, inst} with W-stage data into commit records; F-to-out latency STAGES+1.
// Valid/ready output FIFO; records arriving while full and not draining are dropped and counted.
module proc_trace_commit_buffer #(
    parameter int STAGES = 4,
    parameter int DEPTH  = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     trace_val,
    input  logic [31:0]              trace_addr,
    input  logic [31:0]              trace_inst,
    input  logic [31:0]              trace_data,
    input  logic                     clr,
    output logic                     out_val,
    input  logic                     out_rdy,
    output logic [31:0]              out_addr,
    output logic [31:0]              out_inst,
    output logic [31:0]              out_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic [7:0]               drop_count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] inst;
        logic [31:0] data;
    } rec_t;

    logic [STAGES-1:0] val_q, val_d;
    logic [31:0]       addr_q [STAGES];
    logic [31:0]       addr_d [STAGES];
    logic [31:0]       inst_q [STAGES];
    logic [31:0]       inst_d [STAGES];

    rec_t              mem_q [DEPTH];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic              overflow_q, overflow_d;
    logic [7:0]        drop_q, drop_d;

    logic              enq, deq, full, wr_en, drop;
    logic [7:0]        drop_base;
    rec_t              w_rec, head;

    // Delay line has no stall: every slot shifts every cycle.
    always_comb begin
        val_d[0]  = trace_val;
        addr_d[0] = trace_addr;
        inst_d[0] = trace_inst;
        for (int k = 1; k < STAGES; k++) begin
            val_d[k]  = val_q[k-1];
            addr_d[k] = addr_q[k-1];
            inst_d[k] = inst_q[k-1];
        end
    end

    always_comb begin
        enq        = val_q[STAGES-1];
        full       = (count_q == CW'(DEPTH));
        out_val    = (count_q != '0);
        deq        = out_val && out_rdy;
        // A full FIFO still accepts when the head leaves in the same cycle.
        wr_en      = enq && (!full || deq);
        drop       = enq && full && !deq;
        w_rec      = '{addr: addr_q[STAGES-1], inst: inst_q[STAGES-1], data: trace_data};

        wr_ptr_d   = wr_en ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d   = deq ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d    = count_q + {{AW{1'b0}}, wr_en} - {{AW{1'b0}}, deq};

        drop_base  = clr ? 8'd0 : drop_q;
        overflow_d = clr ? 1'b0 : overflow_q;
        drop_d     = drop_base;
        if (drop) begin
            overflow_d = 1'b1;
            if (drop_base != 8'hFF) begin
                drop_d = drop_base + 8'd1;
            end
        end

        head       = mem_q[rd_ptr_q];
        out_addr   = out_val ? head.addr : 32'd0;
        out_inst   = out_val ? head.inst : 32'd0;
        out_data   = out_val ? head.data : 32'd0;
        count      = count_q;
        overflow   = overflow_q;
        drop_count = drop_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            val_q      <= '0;
            for (int k = 0; k < STAGES; k++) begin
                addr_q[k] <= '0;
                inst_q[k] <= '0;
            end
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            drop_q     <= '0;
        end else begin
            val_q      <= val_d;
            for (int k = 0; k < STAGES; k++) begin
                addr_q[k] <= addr_d[k];
                inst_q[k] <= inst_d[k];
            end
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            drop_q     <= drop_d;
        end
    end

    // Storage needs no reset: reads are masked to zero while empty.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= w_rec;
        end
    end

endmodule

// File: tb/tb_proc_trace_commit_buffer.sv
// Bench for proc_trace_commit_buffer: vector table plus hand sequences, scoreboarded every cycle.
module tb_proc_trace_commit_buffer;
    localparam int STAGES = 4;
    localparam int DEPTH  = 8;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] inst;
        logic [31:0] data;
    } rec_t;

    typedef struct {
        int   due;
        rec_t rec;
    } pend_t;

    typedef struct {
        logic        val;
        logic [31:0] addr;
        logic [31:0] inst;
        logic [31:0] data;
        logic        rdy;
        logic        clr;
        logic        chk;
        logic        exp_val;
        logic [31:0] exp_addr;
        int          exp_cnt;
        logic        exp_ovf;
        int          exp_drop;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        trace_val;
    logic [31:0] trace_addr, trace_inst, trace_data;
    logic        clr;
    logic        out_val, out_rdy;
    logic [31:0] out_addr, out_inst, out_data;
    logic [3:0]  count;
    logic        overflow;
    logic [7:0]  drop_count;

    always #5 clk = ~clk;

    proc_trace_commit_buffer #(.STAGES(STAGES), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .trace_val(trace_val), .trace_addr(trace_addr), .trace_inst(trace_inst),
        .trace_data(trace_data), .clr(clr),
        .out_val(out_val), .out_rdy(out_rdy),
        .out_addr(out_addr), .out_inst(out_inst), .out_data(out_data),
        .count(count), .overflow(overflow), .drop_count(drop_count)
    );

    int    n_tests = 0;
    int    n_fail  = 0;
    int    cyc     = 0;
    rec_t  ref_q[$];
    pend_t pend[$];
    logic  ref_ovf = 1'b0;
    int    ref_drop = 0;
    vec_t  tbl[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s (cycle %0d): got %h, expected %h", name, cyc, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic v, input logic [31:0] a, input logic [31:0] i,
                                input logic [31:0] d, input logic r, input logic c);
        vec_t e;
        e.val = v; e.addr = a; e.inst = i; e.data = d; e.rdy = r; e.clr = c;
        e.chk = 1'b0; e.exp_val = 1'b0; e.exp_addr = '0;
        e.exp_cnt = 0; e.exp_ovf = 1'b0; e.exp_drop = 0;
        return e;
    endfunction

    task automatic add(input logic v, input logic [31:0] a, input logic [31:0] i,
                       input logic [31:0] d, input logic r, input logic c);
        tbl.push_back(mk(v, a, i, d, r, c));
    endtask

    task automatic add_chk(input logic v, input logic [31:0] a, input logic r, input logic c,
                           input logic ev, input logic [31:0] ea, input int ecnt,
                           input logic eovf, input int edrop);
        vec_t e;
        e = mk(v, a, 32'h0000_0013, 32'h0, r, c);
        e.chk = 1'b1; e.exp_val = ev; e.exp_addr = ea;
        e.exp_cnt = ecnt; e.exp_ovf = eovf; e.exp_drop = edrop;
        tbl.push_back(e);
    endtask

    task automatic check_outputs();
        rec_t h;
        h = '0;
        if (ref_q.size() != 0) h = ref_q[0];
        chk("out_val",    32'(out_val),    32'(ref_q.size() != 0));
        chk("count",      32'(count),      32'(ref_q.size()));
        chk("overflow",   32'(overflow),   32'(ref_ovf));
        chk("drop_count", 32'(drop_count), 32'(ref_drop));
        chk("out_addr",   out_addr,        h.addr);
        chk("out_inst",   out_inst,        h.inst);
        chk("out_data",   out_data,        h.data);
    endtask

    // Called #1 after a posedge; drives one cycle, samples mid-cycle, advances the reference.
    task automatic tick(input vec_t e);
        logic  w_now, deq, full, dropped;
        pend_t p;
        trace_val  = e.val;
        trace_addr = e.addr;
        trace_inst = e.inst;
        out_rdy    = e.rdy;
        clr        = e.clr;
        if (e.val) begin
            p.due      = cyc + STAGES;
            p.rec.addr = e.addr;
            p.rec.inst = e.inst;
            p.rec.data = e.data;
            pend.push_back(p);
        end
        w_now      = (pend.size() != 0) && (pend[0].due == cyc);
        trace_data = w_now ? pend[0].rec.data : $urandom();
        #3;
        check_outputs();
        if (e.chk) begin
            chk("tbl.out_val", 32'(out_val), 32'(e.exp_val));
            if (e.exp_val) chk("tbl.out_addr", out_addr, e.exp_addr);
            chk("tbl.count", 32'(count), 32'(e.exp_cnt));
            chk("tbl.overflow", 32'(overflow), 32'(e.exp_ovf));
            chk("tbl.drop_count", 32'(drop_count), 32'(e.exp_drop));
        end
        full    = (ref_q.size() == DEPTH);
        deq     = (ref_q.size() != 0) && e.rdy;
        dropped = 1'b0;
        if (deq) void'(ref_q.pop_front());
        if (w_now) begin
            p = pend.pop_front();
            if (!full || deq) ref_q.push_back(p.rec);
            else dropped = 1'b1;
        end
        if (e.clr) begin
            ref_ovf  = 1'b0;
            ref_drop = 0;
        end
        if (dropped) begin
            ref_ovf = 1'b1;
            if (ref_drop < 255) ref_drop++;
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic hold_reset(input int n);
        rst = 1'b0;
        ref_q.delete();
        pend.delete();
        ref_ovf  = 1'b0;
        ref_drop = 0;
        for (int k = 0; k < n; k++) begin
            trace_val  = 1'($urandom());
            trace_addr = $urandom();
            trace_inst = $urandom();
            trace_data = $urandom();
            out_rdy    = 1'($urandom());
            clr        = 1'($urandom());
            #2;
            chk("rst.out_val",    32'(out_val),    32'd0);
            chk("rst.count",      32'(count),      32'd0);
            chk("rst.overflow",   32'(overflow),   32'd0);
            chk("rst.drop_count", 32'(drop_count), 32'd0);
            chk("rst.out_addr",   out_addr,        32'd0);
            chk("rst.out_inst",   out_inst,        32'd0);
            chk("rst.out_data",   out_data,        32'd0);
            @(posedge clk);
            #1;
        end
        trace_val = 1'b0;
        out_rdy   = 1'b0;
        clr       = 1'b0;
        rst       = 1'b1;
    endtask

    initial begin
        // Latency: one addi, visible STAGES+1 cycles later for exactly one cycle.
        add(1, 32'h200, 32'h0050_0093, 32'h5, 1, 0);
        for (int k = 1; k <= 4; k++) add_chk(0, 0, 1, 0, 0, 0, 0, 0, 0);
        add_chk(0, 0, 1, 0, 1, 32'h200, 1, 0, 0);
        add_chk(0, 0, 1, 0, 0, 0, 0, 0, 0);
        // Back-to-back retire of a dependent sequence.
        add(1, 32'h200, 32'h0020_0093, 32'h2, 1, 0);
        add(1, 32'h204, 32'h0030_0113, 32'h3, 1, 0);
        add(1, 32'h208, 32'h0020_81B3, 32'h5, 1, 0);
        add(0, 0, 0, 0, 1, 0);
        add(0, 0, 0, 0, 1, 0);
        add_chk(0, 0, 1, 0, 1, 32'h200, 1, 0, 0);
        add_chk(0, 0, 1, 0, 1, 32'h204, 1, 0, 0);
        add_chk(0, 0, 1, 0, 1, 32'h208, 1, 0, 0);
        add_chk(0, 0, 1, 0, 0, 0, 0, 0, 0);
        // Bubble in the middle yields exactly two records.
        add(1, 32'h300, 32'h0010_0093, 32'hA, 1, 0);
        add(0, 32'h304, 32'hDEAD_BEEF, 32'hB, 1, 0);
        add(1, 32'h308, 32'h0030_0093, 32'hC, 1, 0);
        add(0, 0, 0, 0, 1, 0);
        add(0, 0, 0, 0, 1, 0);
        add_chk(0, 0, 1, 0, 1, 32'h300, 1, 0, 0);
        add_chk(0, 0, 1, 0, 0, 0, 0, 0, 0);
        add_chk(0, 0, 1, 0, 1, 32'h308, 1, 0, 0);
        add_chk(0, 0, 1, 0, 0, 0, 0, 0, 0);
        // Fill with no consumer: ten fetches into eight entries.
        for (int k = 0; k < 10; k++) begin
            if (k == 4)      add_chk(1, 32'h200 + 32'(4 * k), 0, 0, 0, 0, 0, 0, 0);
            else if (k == 5) add_chk(1, 32'h200 + 32'(4 * k), 0, 0, 1, 32'h200, 1, 0, 0);
            else if (k == 9) add_chk(1, 32'h200 + 32'(4 * k), 0, 0, 1, 32'h200, 5, 0, 0);
            else add(1, 32'h200 + 32'(4 * k), 32'h0000_0013 | 32'(k << 20), 32'h100 + 32'(k), 0, 0);
        end
        add(0, 0, 0, 0, 0, 0);
        add(0, 0, 0, 0, 0, 0);
        add_chk(0, 0, 0, 0, 1, 32'h200, 8, 0, 0);
        add_chk(0, 0, 0, 0, 1, 32'h200, 8, 1, 1);
        add_chk(0, 0, 0, 0, 1, 32'h200, 8, 1, 2);
        add_chk(0, 0, 0, 0, 1, 32'h200, 8, 1, 2);
        // Drain in order, then clear the sticky status.
        for (int k = 0; k < 8; k++) add_chk(0, 0, 1, 0, 1, 32'h200 + 32'(4 * k), 8 - k, 1, 2);
        add_chk(0, 0, 1, 0, 0, 0, 0, 1, 2);
        add_chk(0, 0, 1, 1, 0, 0, 0, 1, 2);
        add_chk(0, 0, 1, 0, 0, 0, 0, 0, 0);

        hold_reset(4);
        for (int k = 0; k < 10; k++) tick(mk(0, 0, 0, 0, 1'($urandom()), 0));

        for (int k = 0; k < tbl.size(); k++) tick(tbl[k]);

        // Full FIFO with simultaneous enqueue and dequeue, then one drop.
        for (int r = 0; r < 19; r++) begin
            vec_t e;
            e = mk(r < 14, 32'h400 + 32'(4 * r), 32'h0000_0033 | 32'(r << 7),
                   32'h1000 + 32'(r), (r >= 12) && (r <= 16), 0);
            if (r >= 12 && r <= 17) begin
                e.chk = 1'b1; e.exp_val = 1'b1; e.exp_addr = 32'h400 + 32'(4 * (r - 12));
                e.exp_cnt = 8; e.exp_ovf = 1'b0; e.exp_drop = 0;
            end
            tick(e);
        end
        chk("pre_rst.drop_count", 32'(drop_count), 32'd1);
        chk("pre_rst.count", 32'(count), 32'd8);

        // Asynchronous reset mid-cycle clears everything at once.
        trace_val = 1'b1;
        out_rdy   = 1'b0;
        #1;
        hold_reset(3);
        for (int k = 0; k < 6; k++) tick(mk(0, 0, 0, 0, 1, 0));
        tick(mk(1, 32'h500, 32'h0070_0093, 32'h7, 1, 0));
        for (int k = 0; k < 7; k++) tick(mk(0, 0, 0, 0, 1, 0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
